// File: rtl/decoder_scan_nx_if.sv
// Bus bundle for decoder_scan_nx: enable/mode/select inputs and the
// registered one-hot outputs. When DEC_REVERSE_EN is defined the bundle
// also carries the DIR scan-direction input.
interface decoder_scan_nx_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 1 << SEL_W;

  logic             E;
  logic             MODE;
  logic [SEL_W-1:0] S;
  logic [OUT_W-1:0] D;
  logic [SEL_W-1:0] IDX;
  logic             WRAP;
`ifdef DEC_REVERSE_EN
  logic             DIR;

  modport master (output E, MODE, S, DIR, input D, IDX, WRAP);
  modport slave  (input E, MODE, S, DIR, output D, IDX, WRAP);
`else
  modport master (output E, MODE, S, input D, IDX, WRAP);
  modport slave  (input E, MODE, S, output D, IDX, WRAP);
`endif
endinterface

// File: rtl/decoder_scan_nx.sv
// decoder_scan_nx: registered SEL_W-to-2**SEL_W one-hot decoder with an
// auto-scan mode that walks the active line across all outputs, holding
// each line for DWELL clocks. Optional feature macro: DEC_REVERSE_EN adds a
// DIR input that lets the scan run downward.
module decoder_scan_nx #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input logic              CLK,
  input logic              RST,
  decoder_scan_nx_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(OUT_W - 1);
  localparam logic [SEL_W-1:0] ZERO_IDX   = {SEL_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [SEL_W-1:0] idx;
  logic [OUT_W-1:0] d;
  logic             wrap;

  logic             scan_down;
  logic [SEL_W-1:0] step_idx;
  logic             step_wrap;
  logic [SEL_W-1:0] start_idx;

  // Single-bit one-hot expansion of a line index.
  function automatic logic [OUT_W-1:0] one_hot(input logic [SEL_W-1:0] sel);
    one_hot = {{(OUT_W-1){1'b0}}, 1'b1} << sel;
  endfunction

`ifdef DEC_REVERSE_EN
  assign scan_down = bus.DIR;
`else
  assign scan_down = 1'b0;
`endif

  assign bus.D    = d;
  assign bus.IDX  = idx;
  assign bus.WRAP = wrap;

  // Next scan position and wrap flag for the current direction.
  always_comb begin
    step_idx  = idx + SEL_W'(1);
    step_wrap = (idx == LAST_IDX);
    start_idx = ZERO_IDX;
    if (scan_down) begin
      step_idx  = idx - SEL_W'(1);
      step_wrap = (idx == ZERO_IDX);
      start_idx = LAST_IDX;
    end else begin
      step_idx  = idx + SEL_W'(1);
      step_wrap = (idx == LAST_IDX);
      start_idx = ZERO_IDX;
    end
  end

  // Mode FSM with registered outputs; enable has priority over mode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      dwell_cnt <= {CNT_W{1'b0}};
      idx       <= ZERO_IDX;
      d         <= {OUT_W{1'b0}};
      wrap      <= 1'b0;
    end else if (!bus.E) begin
      state     <= IDLE;
      dwell_cnt <= {CNT_W{1'b0}};
      idx       <= ZERO_IDX;
      d         <= {OUT_W{1'b0}};
      wrap      <= 1'b0;
    end else if (!bus.MODE) begin
      // Direct decode; any scan position is dropped.
      state     <= DIRECT;
      dwell_cnt <= {CNT_W{1'b0}};
      idx       <= bus.S;
      d         <= one_hot(bus.S);
      wrap      <= 1'b0;
    end else if (state != SCAN) begin
      // Fresh scan entry always starts at the first line of the direction.
      state     <= SCAN;
      dwell_cnt <= {CNT_W{1'b0}};
      idx       <= start_idx;
      d         <= one_hot(start_idx);
      wrap      <= 1'b0;
    end else if (dwell_cnt == DWELL_LAST) begin
      state     <= SCAN;
      dwell_cnt <= {CNT_W{1'b0}};
      idx       <= step_idx;
      d         <= one_hot(step_idx);
      wrap      <= step_wrap;
    end else begin
      state     <= SCAN;
      dwell_cnt <= dwell_cnt + CNT_W'(1);
      idx       <= idx;
      d         <= d;
      wrap      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decoder_scan_nx.sv
// Scoreboard bench for decoder_scan_nx: a behavioural model computes the
// expected outputs per cycle from the scan position since entry, queues them
// when inputs are driven and compares after the clock edge.
module tb_decoder_scan_nx;
  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  decoder_scan_nx_if #(.SEL_W(3)) ia ();
  decoder_scan_nx #(.SEL_W(3), .DWELL(4)) dut_a (.CLK(CLK), .RST(RST), .bus(ia));

  decoder_scan_nx_if #(.SEL_W(2)) ib ();
  decoder_scan_nx #(.SEL_W(2), .DWELL(1)) dut_b (.CLK(CLK), .RST(RST), .bus(ib));

`ifdef DEC_REVERSE_EN
  decoder_scan_nx_if #(.SEL_W(3)) ic ();
  decoder_scan_nx #(.SEL_W(3), .DWELL(2)) dut_c (.CLK(CLK), .RST(RST), .bus(ic));
`endif

  typedef struct packed {
    logic        wrap;
    logic [7:0]  idx;
    logic [63:0] d;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int checks = 0;
  int errors = 0;
  int st_a = 0, pos_a = 0;
  int st_b = 0, pos_b = 0;
  int st_c = 0, pos_c = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: state 0 idle, 1 direct, 2 scan; pos counts scan cycles.
  task automatic model(input int n, input int dwell, input bit rev, input bit e,
                       input bit mode, input int s, inout int st, inout int pos,
                       output exp_t x);
    int k;
    x = '0;
    if (!e) begin
      st = 0;
      pos = 0;
    end else if (!mode) begin
      st = 1;
      x.idx = 8'(s % n);
      x.d = 64'd1 << (s % n);
    end else begin
      if (st != 2) begin
        st = 2;
        pos = 0;
      end else begin
        pos++;
      end
      k = (pos / dwell) % n;
      x.idx = rev ? 8'(n - 1 - k) : 8'(k);
      x.d = 64'd1 << x.idx;
      x.wrap = (pos > 0) && ((pos % (dwell * n)) == 0);
    end
  endtask

  task automatic cmp(input string name, input exp_t e, input logic [63:0] d,
                     input logic [7:0] idx, input logic w);
    check_val({name, ".D"}, d, e.d);
    check_val({name, ".IDX"}, 64'(idx), 64'(e.idx));
    check_val({name, ".WRAP"}, 64'(w), 64'(e.wrap));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".a.D"}, 64'(ia.D), 64'd0);
    check_val({tag, ".a.IDX"}, 64'(ia.IDX), 64'd0);
    check_val({tag, ".a.WRAP"}, 64'(ia.WRAP), 64'd0);
    check_val({tag, ".b.D"}, 64'(ib.D), 64'd0);
    check_val({tag, ".b.WRAP"}, 64'(ib.WRAP), 64'd0);
`ifdef DEC_REVERSE_EN
    check_val({tag, ".c.D"}, 64'(ic.D), 64'd0);
    check_val({tag, ".c.WRAP"}, 64'(ic.WRAP), 64'd0);
`endif
  endtask

  // One clock: drive at the falling edge, predict, compare after rising edge.
  task automatic cyc(input bit e, input bit mode, input int s);
    exp_t x;
    @(negedge CLK);
    ia.E = e; ia.MODE = mode; ia.S = 3'(s);
    ib.E = e; ib.MODE = mode; ib.S = 2'(s);
    model(8, 4, 1'b0, e, mode, s, st_a, pos_a, x);
    qa.push_back(x);
    model(4, 1, 1'b0, e, mode, s, st_b, pos_b, x);
    qb.push_back(x);
`ifdef DEC_REVERSE_EN
    ic.E = e; ic.MODE = mode; ic.S = 3'(s); ic.DIR = 1'b1;
    model(8, 2, 1'b1, e, mode, s, st_c, pos_c, x);
    qc.push_back(x);
`endif
    @(posedge CLK);
    #1;
    if (qa.size() == 0) check_val("a.queue", 64'd0, 64'd1);
    else cmp("a", qa.pop_front(), 64'(ia.D), 8'(ia.IDX), ia.WRAP);
    if (qb.size() == 0) check_val("b.queue", 64'd0, 64'd1);
    else cmp("b", qb.pop_front(), 64'(ib.D), 8'(ib.IDX), ib.WRAP);
`ifdef DEC_REVERSE_EN
    if (qc.size() == 0) check_val("c.queue", 64'd0, 64'd1);
    else cmp("c", qc.pop_front(), 64'(ic.D), 8'(ic.IDX), ic.WRAP);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    ia.E = 1'b0; ia.MODE = 1'b0; ia.S = 3'd0;
    ib.E = 1'b0; ib.MODE = 1'b0; ib.S = 2'd0;
`ifdef DEC_REVERSE_EN
    ic.E = 1'b0; ic.MODE = 1'b0; ic.S = 3'd0; ic.DIR = 1'b1;
`endif
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Released with E=0: outputs stay low.
    repeat (2) cyc(1'b0, 1'b0, 0);

    // Direct sweep over every select value.
    for (int s = 0; s < 8; s++) cyc(1'b1, 1'b0, s);

    // Two-plus full scan periods, covering WRAP on both instances.
    repeat (70) cyc(1'b1, 1'b1, 0);

    // Disable while line 5 is active.
    cyc(1'b1, 1'b0, 0);
    repeat (21) cyc(1'b1, 1'b1, 0);
    cyc(1'b0, 1'b1, 0);

    // Scan to mid-dwell, switch to direct S=6, then restart the scan.
    repeat (22) cyc(1'b1, 1'b1, 0);
    cyc(1'b1, 1'b0, 6);
    repeat (10) cyc(1'b1, 1'b1, 0);

    // Randomised enable/mode/select traffic.
    repeat (300) cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 7)));

    // Asynchronous reset in the middle of a scan.
    repeat (15) cyc(1'b1, 1'b1, 0);
    #2;
    RST = 1'b1;
    #1;
    check_all_zero("async_rst");
    ia.E = 1'b0; ib.E = 1'b0;
`ifdef DEC_REVERSE_EN
    ic.E = 1'b0;
`endif
    st_a = 0; pos_a = 0; st_b = 0; pos_b = 0; st_c = 0; pos_c = 0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) cyc(1'b0, 1'b1, 0);
    repeat (12) cyc(1'b1, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
